// File: rtl/forth_stack_unit.sv
// -----------------------------------------------------------------------------
// forth_stack_unit
//   Parametrised stack for the forth core, used once as the parameter stack and
//   once as the return stack. TOS lives in a register; the other DEPTH-1
//   entries live in an array where, with count=n, NOS sits at index n-2 and
//   the bottom item at index 0. One op is executed per clock.
//
//   Optional build macro: FORTH_STACK_PEEK_EN adds a combinational peek port.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset (tos, count, flags -> 0)
//   op         3'b000 NOP, 001 PUSH, 010 POP, 011 REPL, 100 POPREPL,
//              101 SWAP, 110 DUP, 111 reserved (NOP)
//   din        data for PUSH / REPL / POPREPL
//   err_clr    clears the sticky ovf/unf flags (a same-cycle error wins)
//   tos        top of stack (registered)
//   nos        next on stack (combinational, 0 when count<2)
//   count      items held, 0..DEPTH
//   empty/full count==0 / count==DEPTH
//   ovf/unf    sticky overflow / underflow
//   peek_idx   (FORTH_STACK_PEEK_EN) 0 = tos, k = k-th item below tos
//   peek_data  (FORTH_STACK_PEEK_EN) combinational peek result, 0 past count
// -----------------------------------------------------------------------------
module forth_stack_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,              // must be >= 2
  parameter int CW    = $clog2(DEPTH+1)  // derived, do not override
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic             err_clr,
`ifdef FORTH_STACK_PEEK_EN
  input  logic [CW-1:0]    peek_idx,
  output logic [WIDTH-1:0] peek_data,
`endif
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  // Array index width; at least one bit even for the degenerate DEPTH=2 case.
  localparam int AW = (DEPTH - 1 > 1) ? $clog2(DEPTH - 1) : 1;

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_PUSH    = 3'b001;
  localparam logic [2:0] OP_POP     = 3'b010;
  localparam logic [2:0] OP_REPL    = 3'b011;
  localparam logic [2:0] OP_POPREPL = 3'b100;
  localparam logic [2:0] OP_SWAP    = 3'b101;
  localparam logic [2:0] OP_DUP     = 3'b110;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_TWO  = CW'(2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH-1];

  logic [WIDTH-1:0] tos_q, tos_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [WIDTH-1:0] mem_wd;

  logic [CW-1:0]    cnt_m1, cnt_m2;
  logic [AW-1:0]    top_idx, nos_idx;
  logic             st_empty, st_full, st_ge2;
  logic             ovf_set, unf_set;
  logic [WIDTH-1:0] nos_val;

  assign cnt_m1   = count_q - CNT_ONE;
  assign cnt_m2   = count_q - CNT_TWO;
  // Slot just above NOS (where TOS spills on push) and the NOS slot itself.
  assign top_idx  = cnt_m1[AW-1:0];
  assign nos_idx  = cnt_m2[AW-1:0];

  assign st_empty = (count_q == '0);
  assign st_full  = (count_q == CNT_FULL);
  assign st_ge2   = (count_q >= CNT_TWO);

  // Index is only meaningful with two or more items; mask it otherwise.
  assign nos_val  = st_ge2 ? mem[nos_idx] : '0;

  // Next-state decode. Faulting ops leave tos/count/array untouched and only
  // raise their flag.
  always_comb begin
    tos_d   = tos_q;
    count_d = count_q;
    mem_we  = 1'b0;
    mem_wa  = top_idx;
    mem_wd  = tos_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (op)
      OP_PUSH: begin
        if (st_full) begin
          ovf_set = 1'b1;
        end else begin
          mem_we  = !st_empty;     // first item goes straight into TOS
          tos_d   = din;
          count_d = count_q + CNT_ONE;
        end
      end
      OP_DUP: begin
        if (st_full) begin
          ovf_set = 1'b1;
        end else if (st_empty) begin
          unf_set = 1'b1;
        end else begin
          mem_we  = 1'b1;
          count_d = count_q + CNT_ONE;
        end
      end
      OP_POP: begin
        if (st_empty) begin
          unf_set = 1'b1;
        end else begin
          tos_d   = nos_val;       // already 0 when popping the last item
          count_d = cnt_m1;
        end
      end
      OP_REPL: begin
        if (st_empty) unf_set = 1'b1;
        else          tos_d   = din;
      end
      OP_POPREPL: begin
        if (!st_ge2) begin
          unf_set = 1'b1;
        end else begin
          tos_d   = din;
          count_d = cnt_m1;
        end
      end
      OP_SWAP: begin
        if (!st_ge2) begin
          unf_set = 1'b1;
        end else begin
          tos_d  = nos_val;
          mem_we = 1'b1;
          mem_wa = nos_idx;
        end
      end
      default: ;                   // OP_NOP and reserved 3'b111
    endcase
    // A new error in the same cycle as err_clr keeps the flag set.
    ovf_d = ovf_set | (ovf_q & ~err_clr);
    unf_d = unf_set | (unf_q & ~err_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tos_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      tos_q   <= tos_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Array contents are don't-care after reset; count gates every read.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

`ifdef FORTH_STACK_PEEK_EN
  logic [CW-1:0] peek_off;
  assign peek_off = cnt_m1 - peek_idx;

  always_comb begin
    peek_data = '0;
    if (peek_idx == '0)          peek_data = tos_q;
    else if (peek_idx < count_q) peek_data = mem[peek_off[AW-1:0]];
  end
`endif

  assign tos   = tos_q;
  assign nos   = nos_val;
  assign count = count_q;
  assign empty = st_empty;
  assign full  = st_full;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_forth_stack_unit.sv
module tb_forth_stack_unit;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, REPL = 3'd3,
                         POPREPL = 3'd4, SWAP = 3'd5, DUP = 3'd6, RSVD = 3'd7;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [2:0]       op = NOP;
  logic [WIDTH-1:0] din = '0;
  logic             err_clr = 1'b0;
  logic [WIDTH-1:0] tos, nos;
  logic [CW-1:0]    count;
  logic             empty, full, ovf, unf;
`ifdef FORTH_STACK_PEEK_EN
  logic [CW-1:0]    peek_idx = '0;
  logic [WIDTH-1:0] peek_data;
`endif

  int n_cmp = 0;
  int n_err = 0;

  forth_stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .op(op), .din(din), .err_clr(err_clr),
`ifdef FORTH_STACK_PEEK_EN
    .peek_idx(peek_idx), .peek_data(peek_data),
`endif
    .tos(tos), .nos(nos), .count(count), .empty(empty), .full(full),
    .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one op for one clock edge, then sample 1 time unit after that edge.
  task automatic step(input logic [2:0] o, input logic [WIDTH-1:0] d, input logic clr);
    op = o; din = d; err_clr = clr;
    @(posedge clk); #1;
    op = NOP; din = '0; err_clr = 1'b0;
  endtask

  // Reset pulse placed between clock edges.
  task automatic do_reset();
    reset = 1'b1; #2; reset = 1'b0; #1;
  endtask

  task automatic chk_state(input string tag, input logic [WIDTH-1:0] e_tos,
                           input logic [WIDTH-1:0] e_nos, input int e_cnt);
    chk({tag, ".tos"},   32'(tos),   32'(e_tos));
    chk({tag, ".nos"},   32'(nos),   32'(e_nos));
    chk({tag, ".count"}, 32'(count), 32'(e_cnt));
    chk({tag, ".empty"}, 32'(empty), 32'(e_cnt == 0));
    chk({tag, ".full"},  32'(full),  32'(e_cnt == DEPTH));
  endtask

  initial begin
    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk_state("rst", 16'h0, 16'h0, 0);
    chk("rst.ovf", 32'(ovf), 0);
    chk("rst.unf", 32'(unf), 0);
    #2 reset = 1'b0; #1;

    // Basic push
    step(PUSH, 16'h1000, 0);
    chk_state("push1", 16'h1000, 16'h0, 1);
    step(PUSH, 16'h2000, 0);
    chk_state("push2", 16'h2000, 16'h1000, 2);
    chk("push2.ovf", 32'(ovf), 0);
    chk("push2.unf", 32'(unf), 0);

    // Swap and pop-replace
    do_reset();
    step(PUSH, 16'h1234, 0);
    step(PUSH, 16'h5678, 0);
    step(SWAP, 16'h0, 0);
    chk_state("swap", 16'h1234, 16'h5678, 2);
    step(POPREPL, 16'h68ac, 0);
    chk_state("poprepl", 16'h68ac, 16'h0, 1);
    step(REPL, 16'h0099, 0);
    chk_state("repl", 16'h0099, 16'h0, 1);
    step(RSVD, 16'hffff, 0);
    chk_state("rsvd", 16'h0099, 16'h0, 1);
    chk("rsvd.unf", 32'(unf), 0);

    // Fill, overflow, drain
    do_reset();
    step(PUSH, 16'd1, 0);
    step(PUSH, 16'd2, 0);
    step(PUSH, 16'd3, 0);
    step(PUSH, 16'd4, 0);
    chk_state("fill", 16'd4, 16'd3, 4);
    step(PUSH, 16'd5, 0);
    chk_state("ovf_push", 16'd4, 16'd3, 4);
    chk("ovf_push.ovf", 32'(ovf), 1);
    step(DUP, 16'd0, 0);
    chk_state("ovf_dup", 16'd4, 16'd3, 4);
    step(NOP, 16'd0, 1);
    chk("ovf_clr.ovf", 32'(ovf), 0);
    step(POP, 16'd0, 0);
    chk_state("pop1", 16'd3, 16'd2, 3);
    step(POP, 16'd0, 0);
    chk_state("pop2", 16'd2, 16'd1, 2);
    step(POP, 16'd0, 0);
    chk_state("pop3", 16'd1, 16'd0, 1);
    step(POP, 16'd0, 0);
    chk_state("pop4", 16'd0, 16'd0, 0);
    chk("drain.unf", 32'(unf), 0);

    // Underflow and sticky flag behaviour
    do_reset();
    step(POP, 16'd0, 0);
    chk_state("unf_pop", 16'd0, 16'd0, 0);
    chk("unf_pop.unf", 32'(unf), 1);
    step(PUSH, 16'h0042, 0);
    chk("unf_push.unf", 32'(unf), 1);
    step(SWAP, 16'd0, 1);
    chk_state("unf_swap", 16'h0042, 16'd0, 1);
    chk("unf_swap.unf", 32'(unf), 1);
    step(NOP, 16'd0, 1);
    chk("unf_clr.unf", 32'(unf), 0);
    chk_state("unf_clr", 16'h0042, 16'd0, 1);
    step(POPREPL, 16'h7777, 0);
    chk_state("unf_poprepl", 16'h0042, 16'd0, 1);
    chk("unf_poprepl.unf", 32'(unf), 1);

    // Asynchronous reset between edges
    do_reset();
    chk("rst2.unf", 32'(unf), 0);
    step(PUSH, 16'h0abc, 0);
    step(DUP, 16'h0, 0);
    chk_state("dup", 16'h0abc, 16'h0abc, 2);
    reset = 1'b1; #1;
    chk("async.tos", 32'(tos), 0);
    chk("async.count", 32'(count), 0);
    #2 reset = 1'b0;
    step(PUSH, 16'h7fff, 0);
    chk_state("post_rst", 16'h7fff, 16'h0, 1);

`ifdef FORTH_STACK_PEEK_EN
    do_reset();
    step(PUSH, 16'h11, 0);
    step(PUSH, 16'h22, 0);
    step(PUSH, 16'h33, 0);
    peek_idx = CW'(0); #1 chk("peek0", 32'(peek_data), 32'h33);
    peek_idx = CW'(1); #1 chk("peek1", 32'(peek_data), 32'h22);
    peek_idx = CW'(2); #1 chk("peek2", 32'(peek_data), 32'h11);
    peek_idx = CW'(3); #1 chk("peek3", 32'(peek_data), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
